fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the first fetch address after reset.
REQ-002 Parameter HALT_OP, default 4'hF, is the opcode in instr[15:12] that stops fetching.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port branch_taken, input, 1 bit: the next-PC logic has resolved a redirect.
REQ-006 The block SHALL have port branch_target, input, 16 bits: the redirect address, valid with branch_taken.
REQ-007 The block SHALL have port stall, input, 1 bit: the decode stage cannot accept instr this cycle.
REQ-008 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-009 The block SHALL have port imem_addr, output, 16 bits: the read address, held stable while imem_req=1.
REQ-010 The block SHALL have port imem_rdata, input, 16 bits: the read data, valid with imem_ready.
REQ-011 The block SHALL have port imem_ready, input, 1 bit: the read completes this cycle (>=1 cycle after request; multi-cycle on miss).
REQ-012 The block SHALL have port pc, output, 16 bits: the current fetch address.
REQ-013 The block SHALL have port instr, output, 16 bits: the buffered instruction.
REQ-014 The block SHALL have port instr_pc_plus2, output, 16 bits: the buffered instruction's address+2, consumed by the next-PC logic.
REQ-015 The block SHALL have port instr_valid, output, 1 bit: instr holds a live instruction.
REQ-016 The block SHALL have port halted, output, 1 bit: fetch stopped on HALT_OP.

Function
REQ-017 State machine SHALL have states REQ (read outstanding), DROP (outstanding read to discard), FULL (buffer held, no read), HALT.
REQ-018 REQ SHALL drive imem_req=1 and imem_addr=pc.
REQ-019 In REQ, on imem_ready with no branch_taken, the block SHALL load instr, set instr_pc_plus2=pc+2 and instr_valid=1, and set pc<=pc+2.
REQ-020 After such a load, the next state SHALL be HALT if imem_rdata[15:12]==HALT_OP, else FULL if stall=1, else REQ.
REQ-021 In FULL, imem_req SHALL be 0, and buffer contents SHALL be held until stall=0, then the state SHALL return to REQ.
REQ-022 Consumption rule: a buffered instruction is consumed on any cycle with instr_valid=1 and stall=0; instr_valid SHALL drop the next cycle unless a new load occurs.
REQ-023 branch_taken SHALL have priority over stall, imem_ready and halt.
REQ-024 On branch_taken, pc<=branch_target and instr_valid<=0.
REQ-025 On branch_taken, the next state SHALL be DROP if a read is outstanding without imem_ready this cycle, else REQ.
REQ-026 DROP SHALL hold imem_req=1 and the old address until imem_ready, discard the data, then go to REQ.
REQ-027 branch_taken in DROP SHALL only update pc.
REQ-028 In HALT, imem_req SHALL be 0 and halted SHALL be 1; branch_taken SHALL leave HALT (speculative halt squashed).
REQ-029 PC arithmetic SHALL be 16-bit unsigned and wrap: 16'hFFFE+2 = 16'h0000.
REQ-030 branch_target bit 0 SHALL be ignored (forced 0).

Reset
REQ-031 On rst_n=0, the block SHALL immediately set state=REQ, pc=RESET_PC, instr=16'h0000, instr_pc_plus2=16'h0000, instr_valid=0 and halted=0, with imem_req=0 while rst_n=0.
REQ-032 Reset mid-read SHALL abandon the read; the memory model is reset by the same rst_n.
REQ-033 The first request SHALL be issued in the first clock cycle after rst_n deasserts.

Structure
REQ-034 The state enum and HALT_OP encoding SHALL live in shared package cpu_pkg.
REQ-035 The PC+2 increment SHALL use one PSA_16bit instance (Sub=0); no other sub-modules.

Verification
REQ-036 Reset, imem_ready=1 each cycle after request -> addresses 0,2,4,6 on consecutive reads; instr_valid=1 from 2nd cycle.
REQ-037 stall=1 for 3 cycles with buffer loaded -> instr/instr_pc_plus2 constant, imem_req=0, no pc change; resume with next address.
REQ-038 branch_taken, target 16'h0040, during a 4-cycle read of 16'h0010 -> that read's data never appears on instr; next imem_addr=16'h0040.
REQ-039 imem_rdata=16'hF000 at pc 16'h0008 -> halted=1, imem_req=0 thereafter, pc=16'h000A; branch_taken to 16'h0020 -> fetch resumes at 16'h0020.
REQ-040 pc=16'hFFFE fetch -> instr_pc_plus2=16'h0000, next imem_addr=16'h0000.
REQ-041 rst_n low mid-read with stall=1 and branch_taken=1 -> imem_req=0 and instr_valid=0 immediately; first read after release at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared fetch-side definitions: fetch state encoding, the
//               default halt opcode and the PC step size.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // REQ  : read outstanding, result will be loaded
  // DROP : read outstanding, result will be discarded (redirected)
  // FULL : buffer held for a stalled decode, no read
  // HALT : fetch stopped on a halt opcode
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_DROP = 2'd1,
    ST_FULL = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

  localparam logic [3:0]  HALT_OPCODE = 4'hF;
  localparam logic [15:0] PC_STEP     = 16'd2;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/PSA_16bit.sv
`default_nettype none
// ============================================================================
// Module      : PSA_16bit
// Description : 16-bit parallel add/subtract, wrapping (carry discarded).
//   a, b : operands
//   sub  : 0 -> sum = a + b, 1 -> sum = a - b
//   sum  : 16-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module PSA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum
);

  // Two's-complement subtract: invert b and inject the carry-in.
  assign sum = a + (b ^ {16{sub}}) + {15'd0, sub};

endmodule : PSA_16bit
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-entry instruction fetch buffer with branch redirect,
//               decode stall and halt detection.
//   clk, rst_n          : clock, asynchronous active-low reset
//   branch_taken/target : redirect request and address (bit 0 ignored)
//   stall               : decode cannot accept instr this cycle
//   imem_req/addr       : instruction-memory read request and address
//   imem_rdata/ready    : read data and completion strobe
//   pc                  : current fetch address
//   instr/instr_pc_plus2: buffered instruction and its address + 2
//   instr_valid         : buffer holds a live instruction
//   halted              : fetch stopped on HALT_OP
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = HALT_OPCODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] pc,
  output logic [15:0] instr,
  output logic [15:0] instr_pc_plus2,
  output logic        instr_valid,
  output logic        halted
);

  fetch_state_t r_state;
  fetch_state_t w_next;
  logic [15:0]  r_pc;
  logic [15:0]  r_drop_addr;
  logic [15:0]  r_instr;
  logic [15:0]  r_pc_plus2;
  logic         r_valid;
  logic [15:0]  w_pc_plus2;
  logic [15:0]  w_target;
  logic         w_load;
  logic         w_to_drop;

  PSA_16bit u_pc_inc (
    .a   (r_pc),
    .b   (PC_STEP),
    .sub (1'b0),
    .sum (w_pc_plus2)
  );

  // Instructions are halfword aligned.
  assign w_target = branch_target & 16'hFFFE;

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_to_drop = 1'b0;
    case (r_state)
      ST_REQ: begin
        if (branch_taken) begin
          // A redirect while our read is still pending must let that read
          // finish on the bus before the new address can be issued.
          w_to_drop = ~imem_ready;
          w_next    = imem_ready ? ST_REQ : ST_DROP;
        end else if (imem_ready) begin
          w_load = 1'b1;
          if (imem_rdata[15:12] == HALT_OP) w_next = ST_HALT;
          else if (stall)                   w_next = ST_FULL;
          else                              w_next = ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem_ready) w_next = ST_REQ;
      end
      ST_FULL: begin
        if (branch_taken || !stall) w_next = ST_REQ;
      end
      ST_HALT: begin
        if (branch_taken) w_next = ST_REQ;
      end
      default: w_next = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_REQ;
    else        r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_drop_addr <= 16'h0000;
      r_instr     <= 16'h0000;
      r_pc_plus2  <= 16'h0000;
      r_valid     <= 1'b0;
    end else begin
      if (branch_taken)  r_pc <= w_target;
      else if (w_load)   r_pc <= w_pc_plus2;

      if (w_to_drop)     r_drop_addr <= r_pc;

      if (w_load) begin
        r_instr    <= imem_rdata;
        r_pc_plus2 <= w_pc_plus2;
      end

      // In DROP the buffer is already empty, so clearing on any redirect
      // still leaves a DROP-state branch affecting only the pc.
      if (branch_taken)  r_valid <= 1'b0;
      else if (w_load)   r_valid <= 1'b1;
      else if (!stall)   r_valid <= 1'b0;
    end
  end

  assign imem_req       = rst_n && ((r_state == ST_REQ) || (r_state == ST_DROP));
  assign imem_addr      = (r_state == ST_DROP) ? r_drop_addr : r_pc;
  assign pc             = r_pc;
  assign instr          = r_instr;
  assign instr_pc_plus2 = r_pc_plus2;
  assign instr_valid    = r_valid;
  assign halted         = (r_state == ST_HALT);

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed vector table,
//               hand-written reset sequence and randomized traffic against a
//               behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] pc;
  logic [15:0] instr;
  logic [15:0] instr_pc_plus2;
  logic        instr_valid;
  logic        halted;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .pc             (pc),
    .instr          (instr),
    .instr_pc_plus2 (instr_pc_plus2),
    .instr_valid    (instr_valid),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [15:0] addr;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] p2;
    logic        valid;
    logic        halted;
  } out_t;

  typedef struct {
    logic        st;
    logic        br;
    logic [15:0] tgt;
    logic        rdy;
    logic [15:0] rd;
    out_t        exp;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  // Compare DUT outputs with an expectation; address only matters while a
  // request is expected.
  task automatic check(input string nm, input out_t e);
    bit bad;
    nvec++;
    bad = (imem_req !== e.req) || (e.req && (imem_addr !== e.addr)) ||
          (pc !== e.pc) || (instr !== e.instr) || (instr_pc_plus2 !== e.p2) ||
          (instr_valid !== e.valid) || (halted !== e.halted);
    if (bad) begin
      nerr++;
      $display("FAIL %s @%0t: got req=%b addr=%h pc=%h instr=%h p2=%h valid=%b halted=%b; want req=%b addr=%h pc=%h instr=%h p2=%h valid=%b halted=%b",
               nm, $time, imem_req, imem_addr, pc, instr, instr_pc_plus2, instr_valid, halted,
               e.req, e.addr, e.pc, e.instr, e.p2, e.valid, e.halted);
    end
  endtask

  function automatic out_t mk_out(input logic req, input logic [15:0] addr, input logic [15:0] p,
                                  input logic [15:0] ins, input logic [15:0] p2,
                                  input logic v, input logic h);
    out_t o;
    o.req = req; o.addr = addr; o.pc = p; o.instr = ins; o.p2 = p2; o.valid = v; o.halted = h;
    return o;
  endfunction

  function automatic vec_t mk(input logic st, input logic br, input logic [15:0] tgt,
                              input logic rdy, input logic [15:0] rd, input out_t e);
    vec_t v;
    v.st = st; v.br = br; v.tgt = tgt; v.rdy = rdy; v.rd = rd; v.exp = e;
    return v;
  endfunction

  task automatic drive(input logic st, input logic br, input logic [15:0] tgt,
                       input logic rdy, input logic [15:0] rd);
    stall = st; branch_taken = br; branch_target = tgt; imem_ready = rdy; imem_rdata = rd;
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: the fetch buffer described as a handful of flags
  // (stopped on halt, held for decode, waiting to discard a stale read).
  // --------------------------------------------------------------------------
  logic [15:0] m_pc, m_instr, m_p2, m_drop_addr;
  logic        m_valid, m_halt, m_hold, m_drop;
  int          m_cnt, m_lat;

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_p2 = 16'h0000; m_drop_addr = 16'h0000;
    m_valid = 1'b0; m_halt = 1'b0; m_hold = 1'b0; m_drop = 1'b0;
    m_cnt = 0; m_lat = $urandom_range(1, 4);
  endtask

  function automatic out_t model_out();
    logic req;
    req = !m_halt && !m_hold;
    return mk_out(req, m_drop ? m_drop_addr : m_pc, m_pc, m_instr, m_p2, m_valid, m_halt);
  endfunction

  task automatic model_step(input logic st, input logic br, input logic [15:0] tgt,
                            input logic rdy, input logic [15:0] rd);
    logic req;
    req = !m_halt && !m_hold;
    if (m_drop) begin
      if (br) m_pc = {tgt[15:1], 1'b0};
      if (rdy) m_drop = 1'b0;
    end else if (br) begin
      if (req && !rdy) begin m_drop = 1'b1; m_drop_addr = m_pc; end
      m_pc = {tgt[15:1], 1'b0};
      m_valid = 1'b0; m_halt = 1'b0; m_hold = 1'b0;
    end else if (req && rdy) begin
      m_instr = rd; m_p2 = m_pc + 16'd2; m_pc = m_pc + 16'd2; m_valid = 1'b1;
      m_halt = (rd[15:12] == 4'hF);
      m_hold = !m_halt && st;
    end else begin
      if (!st) begin m_valid = 1'b0; m_hold = 1'b0; end
    end
  endtask

  vec_t tbl[25];

  initial begin
    // ---- directed table: inputs for one cycle, outputs after that edge ----
    tbl[0]  = mk(0,0,16'h0000,1,16'h1000, mk_out(1,16'h0002,16'h0002,16'h1000,16'h0002,1,0));
    tbl[1]  = mk(0,0,16'h0000,1,16'h1002, mk_out(1,16'h0004,16'h0004,16'h1002,16'h0004,1,0));
    tbl[2]  = mk(0,0,16'h0000,1,16'h1004, mk_out(1,16'h0006,16'h0006,16'h1004,16'h0006,1,0));
    tbl[3]  = mk(1,0,16'h0000,1,16'h1006, mk_out(0,16'h0008,16'h0008,16'h1006,16'h0008,1,0));
    tbl[4]  = mk(1,0,16'h0000,0,16'h0000, mk_out(0,16'h0008,16'h0008,16'h1006,16'h0008,1,0));
    tbl[5]  = mk(1,0,16'h0000,0,16'h0000, mk_out(0,16'h0008,16'h0008,16'h1006,16'h0008,1,0));
    tbl[6]  = mk(1,0,16'h0000,0,16'h0000, mk_out(0,16'h0008,16'h0008,16'h1006,16'h0008,1,0));
    tbl[7]  = mk(0,0,16'h0000,0,16'h0000, mk_out(1,16'h0008,16'h0008,16'h1006,16'h0008,0,0));
    tbl[8]  = mk(0,0,16'h0000,1,16'hF000, mk_out(0,16'h000A,16'h000A,16'hF000,16'h000A,1,1));
    tbl[9]  = mk(0,0,16'h0000,0,16'h0000, mk_out(0,16'h000A,16'h000A,16'hF000,16'h000A,0,1));
    tbl[10] = mk(0,0,16'h0000,0,16'h0000, mk_out(0,16'h000A,16'h000A,16'hF000,16'h000A,0,1));
    tbl[11] = mk(0,1,16'h0021,0,16'h0000, mk_out(1,16'h0020,16'h0020,16'hF000,16'h000A,0,0));
    tbl[12] = mk(0,0,16'h0000,0,16'h0000, mk_out(1,16'h0020,16'h0020,16'hF000,16'h000A,0,0));
    tbl[13] = mk(0,0,16'h0000,1,16'h1020, mk_out(1,16'h0022,16'h0022,16'h1020,16'h0022,1,0));
    tbl[14] = mk(0,1,16'h0010,1,16'h1022, mk_out(1,16'h0010,16'h0010,16'h1020,16'h0022,0,0));
    tbl[15] = mk(0,0,16'h0000,0,16'h0000, mk_out(1,16'h0010,16'h0010,16'h1020,16'h0022,0,0));
    tbl[16] = mk(0,1,16'h0040,0,16'h0000, mk_out(1,16'h0010,16'h0040,16'h1020,16'h0022,0,0));
    tbl[17] = mk(0,0,16'h0000,0,16'h0000, mk_out(1,16'h0010,16'h0040,16'h1020,16'h0022,0,0));
    tbl[18] = mk(0,0,16'h0000,1,16'h1010, mk_out(1,16'h0040,16'h0040,16'h1020,16'h0022,0,0));
    tbl[19] = mk(0,0,16'h0000,1,16'h1040, mk_out(1,16'h0042,16'h0042,16'h1040,16'h0042,1,0));
    tbl[20] = mk(0,1,16'hFFFE,0,16'h0000, mk_out(1,16'h0042,16'hFFFE,16'h1040,16'h0042,0,0));
    tbl[21] = mk(0,0,16'h0000,1,16'h9999, mk_out(1,16'hFFFE,16'hFFFE,16'h1040,16'h0042,0,0));
    tbl[22] = mk(0,0,16'h0000,1,16'h1FFE, mk_out(1,16'h0000,16'h0000,16'h1FFE,16'h0000,1,0));
    tbl[23] = mk(1,0,16'h0000,0,16'h0000, mk_out(1,16'h0000,16'h0000,16'h1FFE,16'h0000,1,0));
    tbl[24] = mk(0,0,16'h0000,0,16'h0000, mk_out(1,16'h0000,16'h0000,16'h1FFE,16'h0000,0,0));

    rst_n = 1'b0;
    drive(0, 0, 16'h0000, 0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", mk_out(0,16'h0000,16'h0000,16'h0000,16'h0000,0,0));
    rst_n = 1'b1;
    #1;
    check("first_request", mk_out(1,16'h0000,16'h0000,16'h0000,16'h0000,0,0));

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].st, tbl[i].br, tbl[i].tgt, tbl[i].rdy, tbl[i].rd);
      @(posedge clk);
      #1;
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // ---- reset in the middle of a read, with stall and branch asserted ----
    drive(0, 0, 16'h0000, 1, 16'h1000);
    @(posedge clk);
    #1;
    check("pre_reset_load", mk_out(1,16'h0002,16'h0002,16'h1000,16'h0002,1,0));
    drive(1, 1, 16'h0080, 0, 16'h0000);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", mk_out(0,16'h0000,16'h0000,16'h0000,16'h0000,0,0));
    @(posedge clk);
    #1;
    check("reset_held", mk_out(0,16'h0000,16'h0000,16'h0000,16'h0000,0,0));
    drive(0, 0, 16'h0000, 0, 16'h0000);
    rst_n = 1'b1;
    #1;
    check("reset_release", mk_out(1,16'h0000,16'h0000,16'h0000,16'h0000,0,0));
    drive(0, 0, 16'h0000, 1, 16'h1234);
    @(posedge clk);
    #1;
    check("post_reset_load", mk_out(1,16'h0002,16'h0002,16'h1234,16'h0002,1,0));

    // ---- randomized traffic against the model ----
    rst_n = 1'b0;
    drive(0, 0, 16'h0000, 0, 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rand_start", model_out());
    for (int c = 0; c < 600; c++) begin
      logic        st, br, rdy;
      logic [15:0] tgt, rd;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      tgt = 16'($urandom);
      rd  = 16'($urandom);
      rdy = 1'b0;
      if (model_out().req) begin
        m_cnt++;
        if (m_cnt >= m_lat) begin
          rdy   = 1'b1;
          m_cnt = 0;
          m_lat = $urandom_range(1, 4);
        end
      end
      drive(st, br, tgt, rdy, rd);
      @(posedge clk);
      model_step(st, br, tgt, rdy, rd);
      #1;
      check("random", model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
